// File: rtl/arcade_input_ctrl.sv
// Player-input conditioner: lane routing, per-bit sync/debounce, SOCD cleaning,
// queued coin-pulse shaping and a pause toggle.
//
// coin FSM  state | meaning
//           IDLE  | no pulse in progress, waiting for a coin event
//           PULSE | coin_out high, timer counting down the pulse length
//           GAP   | coin_out low, timer counting down the mandatory gap
module arcade_input_ctrl #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COIN_PULSE      = 4800000,
  parameter int COIN_GAP        = 4800000,
  parameter int PEND_MAX        = 3
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [16*NUM_PLAYERS-1:0] joystick_in,
  input  logic                     merge_mode,
  input  logic                     cocktail,
  output logic [NUM_PLAYERS-1:0]   p_right,
  output logic [NUM_PLAYERS-1:0]   p_left,
  output logic [NUM_PLAYERS-1:0]   p_down,
  output logic [NUM_PLAYERS-1:0]   p_up,
  output logic [NUM_PLAYERS-1:0]   p_btn,
  output logic [1:0]               start_out,
  output logic                     coin_out,
  output logic                     pause_out
);

  localparam int NB   = 5*NUM_PLAYERS + 4;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES+1);
  localparam int TMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int TW   = $clog2(TMAX+1);
  localparam int PW   = (PEND_MAX < 1) ? 1 : $clog2(PEND_MAX+1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES-1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(COIN_PULSE-1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(COIN_GAP-1);
  localparam logic [PW-1:0] PEND_LIM   = PW'(PEND_MAX);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  logic [NB-1:0] raw, sync1, sync2, deb;
  logic [DW-1:0] cnt [NB];
  logic          unused_bits;
  logic          coin_q, pause_q, coin_ev;
  coin_state_t   state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [PW-1:0] pend, pend_d, pend_sat;

  // Lane mux works on raw inputs so mode changes see the same sync latency.
  always_comb begin
    int src;
    raw         = '0;
    unused_bits = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      src = i;
      if (!merge_mode && cocktail && NUM_PLAYERS > 1 && i < 2)
        src = 1 - i;
      if (merge_mode)
        raw[0 +: 5] = raw[0 +: 5] | joystick_in[16*i +: 5];
      else
        raw[5*i +: 5] = joystick_in[16*src +: 5];
      raw[5*NUM_PLAYERS +: 2] = raw[5*NUM_PLAYERS +: 2] | joystick_in[16*i+5 +: 2];
      raw[5*NUM_PLAYERS+2]    = raw[5*NUM_PLAYERS+2] | joystick_in[16*i+7];
      raw[5*NUM_PLAYERS+3]    = raw[5*NUM_PLAYERS+3] | joystick_in[16*i+8];
      unused_bits = unused_bits ^ (^joystick_in[16*i+9 +: 7]);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // SOCD: opposing directions cancel; purely combinational after debounce.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      p_right[i] = deb[5*i]   & ~deb[5*i+1];
      p_left[i]  = deb[5*i+1] & ~deb[5*i];
      p_down[i]  = deb[5*i+2] & ~deb[5*i+3];
      p_up[i]    = deb[5*i+3] & ~deb[5*i+2];
      p_btn[i]   = deb[5*i+4];
    end
    start_out = deb[5*NUM_PLAYERS +: 2];
  end

  assign coin_ev = deb[5*NUM_PLAYERS+2] & ~coin_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_q    <= 1'b0;
      pause_q   <= 1'b0;
      pause_out <= 1'b0;
    end else begin
      coin_q  <= deb[5*NUM_PLAYERS+2];
      pause_q <= deb[5*NUM_PLAYERS+3];
      if (deb[5*NUM_PLAYERS+3] && !pause_q)
        pause_out <= ~pause_out;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      pend  <= '0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      pend  <= pend_d;
    end
  end

  // Events arriving while busy are queued; the GAP-exit test sees this cycle's event.
  always_comb begin
    pend_sat = (coin_ev && pend != PEND_LIM) ? pend + 1'b1 : pend;
    state_d  = state;
    timer_d  = timer;
    pend_d   = pend;
    case (state)
      IDLE: begin
        if (coin_ev) begin
          state_d = PULSE;
          timer_d = PULSE_LOAD;
        end
      end
      PULSE: begin
        pend_d = pend_sat;
        if (timer == '0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      GAP: begin
        pend_d = pend_sat;
        if (timer == '0) begin
          if (pend_sat != '0) begin
            pend_d  = pend_sat - 1'b1;
            state_d = PULSE;
            timer_d = PULSE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coin_out = (state == PULSE);
  end

endmodule
